// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end for a single-port byte-enabled data SRAM.
// Accepts byte/half/word requests, splits accesses that cross a word
// boundary into two SRAM cycles, and returns shifted, extended load data
// through a registered response port. Every output comes from a flop.
module lsu_mem_ctrl #(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [31:0]       REQ_ADDR,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_UNSIGNED,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic              RSP_ERR,
  output logic [31:0]       RSP_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DATA} state_t;

  state_t state_q, state_n;

  logic              accept;
  logic [7:0]        mask_base;
  logic [7:0]        req_mask;
  logic [63:0]       req_wd;
  logic              req_split;

  // Request fields held for the duration of the operation.
  logic              we_q;
  logic              uns_q;
  logic              split_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [3:0]        be_hi_q;
  logic [31:0]       di_hi_q;

  logic [31:0]       lo_q, lo_n;
  logic              err_pend_q, err_pend_n;

  logic              csn_n, wen_n;
  logic [AWIDTH-1:0] addr_n;
  logic [3:0]        be_n;
  logic [31:0]       di_n;
  logic              rsp_valid_n, rsp_err_n;
  logic [31:0]       rdata_n;

  logic [31:0]       hi_word, lo_word, aligned, load_result;

  // Byte-address bits above the SRAM word range are deliberately ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^REQ_ADDR[31:AWIDTH+2];

  assign REQ_READY = (state_q == IDLE);
  assign accept    = REQ_VALID && REQ_READY;

  // Request decode: lane mask and lane-aligned write data over two words.
  always_comb begin
    case (REQ_SIZE)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      default: mask_base = 8'h0F;
    endcase
    req_mask  = mask_base << REQ_ADDR[1:0];
    req_wd    = {32'b0, REQ_WDATA} << {REQ_ADDR[1:0], 3'b000};
    // Any lane landing in the upper word means the access crosses a boundary.
    req_split = |req_mask[7:4];
  end

  // Load datapath: merge both words, shift to byte 0, then extend.
  always_comb begin
    hi_word = split_q ? MEM_DOUT : 32'b0;
    lo_word = split_q ? lo_q     : MEM_DOUT;
    aligned = 32'({hi_word, lo_word} >> {off_q, 3'b000});
    case (size_q)
      2'd0:    load_result = uns_q ? {24'b0, aligned[7:0]}
                                   : {{24{aligned[7]}}, aligned[7:0]};
      2'd1:    load_result = uns_q ? {16'b0, aligned[15:0]}
                                   : {{16{aligned[15]}}, aligned[15:0]};
      default: load_result = aligned;
    endcase
  end

  // Next-state and next registered-output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n     = state_q;
    csn_n       = 1'b1;
    wen_n       = 1'b1;
    addr_n      = MEM_ADDR;
    be_n        = 4'b0;
    di_n        = MEM_DI;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rdata_n     = RSP_RDATA;
    lo_n        = lo_q;
    err_pend_n  = 1'b0;

    case (state_q)
      IDLE: begin
        // An illegal-size request answers one edge after it was accepted.
        if (err_pend_q) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
        end
        if (accept) begin
          if (REQ_SIZE == 2'd3) begin
            err_pend_n = 1'b1;
          end else begin
            state_n = ACC0;
            csn_n   = 1'b0;
            wen_n   = ~REQ_WE;
            addr_n  = REQ_ADDR[AWIDTH+1:2];
            be_n    = REQ_WE ? req_mask[3:0] : 4'b0;
            di_n    = req_wd[31:0];
          end
        end
      end
      ACC0: begin
        if (split_q) begin
          state_n = ACC1;
          csn_n   = 1'b0;
          wen_n   = ~we_q;
          addr_n  = MEM_ADDR + AWIDTH'(1);
          be_n    = we_q ? be_hi_q : 4'b0;
          di_n    = di_hi_q;
        end else if (we_q) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
        end else begin
          state_n = DATA;
        end
      end
      ACC1: begin
        if (we_q) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b1;
        end else begin
          // First word of a split load is on MEM_DOUT during this cycle.
          lo_n    = MEM_DOUT;
          state_n = DATA;
        end
      end
      DATA: begin
        rsp_valid_n = 1'b1;
        rdata_n     = load_result;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset idles the SRAM port immediately.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      MEM_CSN    <= 1'b1;
      MEM_WEN    <= 1'b1;
      MEM_ADDR   <= '0;
      MEM_BE     <= 4'b0;
      MEM_DI     <= 32'b0;
      RSP_VALID  <= 1'b0;
      RSP_ERR    <= 1'b0;
      RSP_RDATA  <= 32'b0;
      lo_q       <= 32'b0;
      err_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_n;
      MEM_CSN    <= csn_n;
      MEM_WEN    <= wen_n;
      MEM_ADDR   <= addr_n;
      MEM_BE     <= be_n;
      MEM_DI     <= di_n;
      RSP_VALID  <= rsp_valid_n;
      RSP_ERR    <= rsp_err_n;
      RSP_RDATA  <= rdata_n;
      lo_q       <= lo_n;
      err_pend_q <= err_pend_n;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= 2'd0;
      off_q   <= 2'd0;
      be_hi_q <= 4'b0;
      di_hi_q <= 32'b0;
    end else if (accept) begin
      we_q    <= REQ_WE;
      uns_q   <= REQ_UNSIGNED;
      split_q <= req_split;
      size_q  <= REQ_SIZE;
      off_q   <= REQ_ADDR[1:0];
      be_hi_q <= req_mask[7:4];
      di_hi_q <= req_wd[63:32];
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a byte-addressed reference memory
// predicts load results, latencies and SRAM lane usage; a word SRAM model
// with byte enables sits on the DUT's memory port.
module tb_lsu_mem_ctrl;

  localparam int AW = 12;
  localparam int NW = 1 << AW;
  localparam int NB = NW * 4;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WE = 1'b0;
  logic [31:0]   REQ_ADDR = '0;
  logic [1:0]    REQ_SIZE = '0;
  logic          REQ_UNSIGNED = 1'b0;
  logic [31:0]   REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_ERR;
  logic [31:0]   RSP_RDATA;
  logic          MEM_CSN;
  logic          MEM_WEN;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_BE;
  logic [31:0]   MEM_DI;
  logic [31:0]   mem_dout = '0;

  lsu_mem_ctrl #(.AWIDTH(AW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR),
    .MEM_BE(MEM_BE), .MEM_DI(MEM_DI), .MEM_DOUT(mem_dout)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   di;
  } acc_t;

  logic [31:0] sram [NW];
  logic [7:0]  ref_mem [NB];
  acc_t        log_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_rdata = '0;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = di[8*k +: 8];
    return r;
  endfunction

  // SRAM model: access on the rising edge, read data valid the next cycle.
  always @(posedge CLK) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    if (MEM_CSN === 1'b0) begin
      log_q.push_back('{we: !MEM_WEN, addr: MEM_ADDR, be: MEM_BE, di: MEM_DI});
      if (MEM_WEN === 1'b0) sram[MEM_ADDR] <= merge(sram[MEM_ADDR], MEM_DI, MEM_BE);
      else                  mem_dout <= sram[MEM_ADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = AW'(w);
    pl_data = d;
    @(posedge CLK);
    #1;
    pl_en = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[4*w + b] = d[8*b +: 8];
  endtask

  // Issue one request, then check latency, response and SRAM traffic.
  task automatic req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input string tag);
    int          n, off, split, exp_lat, exp_acc, lat, base, p;
    logic        bad;
    logic [31:0] val, exp_di, lane_mask;
    logic [3:0]  exp_be;

    bad   = (size == 2'd3);
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = int'(addr[1:0]);
    split = (off + n > 4) ? 1 : 0;
    base  = int'(addr[AW+1:2]);
    exp_acc = bad ? 0 : 1 + split;
    exp_lat = bad ? 1 : (we ? 1 + split : 2 + split);

    if (!bad && !we) begin
      val = '0;
      for (int i = 0; i < n; i++)
        val = val | (32'(ref_mem[int'((addr + 32'(i)) & 32'(NB - 1))]) << (8 * i));
      if (!uns && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
      exp_rdata = val;
    end

    @(negedge CLK);
    REQ_WE = we; REQ_ADDR = addr; REQ_SIZE = size; REQ_UNSIGNED = uns; REQ_WDATA = wdata;
    REQ_VALID = 1'b1;
    for (int t = 0; t < 20 && REQ_READY !== 1'b1; t++) @(negedge CLK);
    check({tag, "_ready"}, 32'(REQ_READY), 32'd1);
    log_q.delete();
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    REQ_WDATA = $urandom;
    REQ_ADDR  = $urandom;
    REQ_SIZE  = 2'($urandom_range(0, 3));

    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK);
      #1;
      if (RSP_VALID === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(RSP_ERR), 32'(bad));
    check({tag, "_rdata"}, RSP_RDATA, exp_rdata);
    check({tag, "_nacc"}, 32'(log_q.size()), 32'(exp_acc));
    for (int j = 0; j < log_q.size() && j < exp_acc; j++) begin
      exp_be = 4'b0; exp_di = '0; lane_mask = '0;
      for (int k = 0; k < 4; k++) begin
        p = 4 * j + k;
        if (we && p >= off && p < off + n) begin
          exp_be[k] = 1'b1;
          lane_mask[8*k +: 8] = 8'hFF;
          exp_di[8*k +: 8] = wdata[8*(p-off) +: 8];
        end
      end
      check({tag, "_acc_addr"}, 32'(log_q[j].addr), 32'((base + j) % NW));
      check({tag, "_acc_we"}, 32'(log_q[j].we), 32'(we));
      check({tag, "_acc_be"}, 32'(log_q[j].be), 32'(exp_be));
      if (we) check({tag, "_acc_di"}, log_q[j].di & lane_mask, exp_di);
    end
    @(posedge CLK);
    #1;
    check({tag, "_pulse"}, 32'(RSP_VALID), 32'd0);

    if (!bad && we)
      for (int i = 0; i < n; i++)
        ref_mem[int'((addr + 32'(i)) & 32'(NB - 1))] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] w0, exp_wrap, a;
    logic [1:0]  sz;
    int          seen;

    // Reset state while held in reset.
    #12;
    check("rst_ready", 32'(REQ_READY), 32'd1);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    check("rst_rdata", RSP_RDATA, 32'd0);
    check("rst_csn", 32'(MEM_CSN), 32'd1);
    check("rst_wen", 32'(MEM_WEN), 32'd1);
    check("rst_be", 32'(MEM_BE), 32'd0);
    check("rst_addr", 32'(MEM_ADDR), 32'd0);
    check("rst_di", MEM_DI, 32'd0);

    // Memory contents for the regions the bench touches.
    preload(0, 32'h44332211);
    preload(1, 32'h88776655);
    for (int w = 2; w <= 8; w++) preload(w, $urandom);
    for (int w = NW - 8; w < NW; w++) preload(w, $urandom);

    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    check("idle_csn", 32'(MEM_CSN), 32'd1);

    // Directed loads.
    req(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, "lw0");
    check("tp_lw0", RSP_RDATA, 32'h44332211);
    req(1'b0, 32'h7, 2'd0, 1'b0, 32'h0, "lb7");
    check("tp_lb7", RSP_RDATA, 32'hFFFFFF88);
    req(1'b0, 32'h7, 2'd0, 1'b1, 32'h0, "lbu7");
    check("tp_lbu7", RSP_RDATA, 32'h00000088);
    req(1'b0, 32'h2, 2'd1, 1'b0, 32'h0, "lh2");
    check("tp_lh2", RSP_RDATA, 32'h00004433);
    req(1'b0, 32'h3, 2'd2, 1'b0, 32'h0, "lw3");
    check("tp_lw3", RSP_RDATA, 32'h77665544);

    // Split half store across words 0 and 1.
    req(1'b1, 32'h3, 2'd1, 1'b0, 32'h0000BEEF, "sh3");
    check("tp_sh3_be0", 32'(log_q[0].be), 32'b1000);
    check("tp_sh3_di0", log_q[0].di, 32'hEF000000);
    check("tp_sh3_be1", 32'(log_q[1].be), 32'b0001);
    check("tp_sh3_di1", log_q[1].di, 32'h000000BE);
    check("tp_sh3_keep", RSP_RDATA, 32'h77665544);
    req(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, "rb0");
    check("tp_rb0", RSP_RDATA, 32'hEF332211);
    req(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, "rb4");
    check("tp_rb4", RSP_RDATA, 32'h887766BE);

    // Word-address wrap at the top of the SRAM.
    exp_wrap = {sram[0][15:0], sram[NW-1][31:16]};
    req(1'b0, 32'h3FFE, 2'd2, 1'b0, 32'h0, "lwwrap");
    check("tp_wrap_a0", 32'(log_q[0].addr), 32'h0FFF);
    check("tp_wrap_a1", 32'(log_q[1].addr), 32'h0000);
    check("tp_wrap_data", RSP_RDATA, exp_wrap);

    // Illegal size: no SRAM access, error response one edge later.
    req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, "illegal");

    // Reset during ACC0 of an aligned store.
    w0 = sram[0];
    @(negedge CLK);
    REQ_WE = 1'b1; REQ_ADDR = 32'h0; REQ_SIZE = 2'd2; REQ_WDATA = 32'h12345678;
    REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
    check("mid_acc0_csn", 32'(MEM_CSN), 32'd0);
    #2;
    RSTn = 1'b0;
    #1;
    check("mid_rst_csn", 32'(MEM_CSN), 32'd1);
    check("mid_rst_wen", 32'(MEM_WEN), 32'd1);
    @(negedge CLK);
    RSTn = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      if (RSP_VALID === 1'b1) seen++;
    end
    check("mid_no_rsp", 32'(seen), 32'd0);
    check("mid_word0", sram[0], w0);
    check("mid_ready", 32'(REQ_READY), 32'd1);
    check("mid_rdata", RSP_RDATA, 32'd0);
    exp_rdata = '0;

    // Randomized mix near both ends of the address space.
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 31))
                                      : 32'h3FE0 + 32'($urandom_range(0, 31));
      a = a | ($urandom & 32'hFFFF_C000);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store front-end sitting directly upstream of the single-port data SRAM (active-low CSN, active-low WEN, byte enables BE, word address, read data valid the cycle after the access edge).
- Accepts byte-addressed load/store requests of byte, half or word size from the pipeline MEM stage.
- Generates SRAM word address, BE and lane-aligned write data; splits misaligned accesses into two SRAM accesses.
- Merges, shifts and sign- or zero-extends load data into a registered response.

Parameters:
AWIDTH, 12, SRAM word-address width; byte address bits [AWIDTH+1:2] select the word, higher bits are ignored.

Ports:
CLK  in  1  clock; all state updates on rising edge.
RSTn  in  1  asynchronous active-low reset.
REQ_VALID  in  1  request present.
REQ_READY  out  1  request accepted on an edge where REQ_VALID and REQ_READY are both 1.
REQ_WE  in  1  1 = store, 0 = load.
REQ_ADDR  in  32  byte address.
REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ_UNSIGNED  in  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ_WDATA  in  32  store data, right-justified.
RSP_VALID  out  1  one-cycle pulse: load data ready or store complete.
RSP_ERR  out  1  qualifies RSP_VALID; illegal size.
RSP_RDATA  out  32  load result.
MEM_CSN  out  1  SRAM chip select, active low.
MEM_WEN  out  1  SRAM write enable, active low (0 = write).
MEM_ADDR  out  AWIDTH  SRAM word address.
MEM_BE  out  4  SRAM byte enables.
MEM_DI  out  32  SRAM write data.
MEM_DOUT  in  32  SRAM read data; valid the cycle after the read edge.

Behaviour:
Reset:
- State goes to IDLE.
- REQ_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
- MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DI=0.

Registering:
- All outputs decode from flops only; no combinational path from REQ_* to MEM_*.
- The request is latched at acceptance.

Decode (at accept):
- off = ADDR[1:0].
- nbytes = 1 / 2 / 4 by size.
- split = (off + nbytes > 4). A byte access never splits; a half splits only at off=3.
- mask8 = ((1<<nbytes)-1) << off.
- wd64 = WDATA << 8*off.
- First access: word ADDR[AWIDTH+1:2], BE = mask8[3:0], DI = wd64[31:0].
- Second access: word +1 modulo 2^AWIDTH (wraps), BE = mask8[7:4], DI = wd64[63:32].
- Reads drive BE=0 and WEN=1.

States:
- IDLE: REQ_READY=1, MEM_CSN=1.
  - On accept with size 3: stay IDLE; at the next edge RSP_VALID=1, RSP_ERR=1, RSP_RDATA unchanged; no SRAM access.
  - On any other accept: go to ACC0.
- ACC0: first access driven (CSN=0).
  - Store: split goes to ACC1; otherwise go to IDLE with RSP_VALID=1.
  - Load: split goes to ACC1; otherwise go to DATA.
- ACC1: second access driven.
  - Load: MEM_DOUT holds the first word; capture it as lo at the edge.
  - Store goes to IDLE with RSP_VALID; load goes to DATA.
- DATA: MEM_CSN=1.
  - Capture MEM_DOUT as hi if split, else as lo; hi=0 when not split.
  - RSP_RDATA = extend(({hi,lo} >> 8*off)[8*nbytes-1:0]).
  - RSP_VALID=1; go to IDLE.

Latency (from accept edge E0):
- Aligned store: RSP_VALID at E1.
- Split store: RSP_VALID at E2.
- Aligned load: RSP_VALID at E2.
- Split load: RSP_VALID at E3.

Handshake and output rules:
- REQ_READY=1 only in IDLE; at most one outstanding request.
- A new request can be accepted in the cycle RSP_VALID is high.
- RSP_VALID has no backpressure.
- RSP_RDATA holds until the next load response; stores do not change it.

Reset mid-operation:
- MEM_CSN=1 and WEN=1 immediately.
- An access not yet sampled by an edge is never performed.
- The first half of a split store may already be written; this is accepted.
- The pending response is dropped.

Test Plan:
- Preload word0=0x44332211, word1=0x88776655. LW at 0x0 -> one CSN-low cycle, ADDR 0; RSP_VALID at E2; RSP_RDATA=0x44332211.
- LB at 0x7 signed -> 0xFFFFFF88. LBU at 0x7 -> 0x00000088. LH at 0x2 -> 0x00004433.
- LW at 0x3 -> reads of word 0 then word 1 in consecutive cycles; RSP_VALID at E3; RSP_RDATA=0x77665544.
- SH 0x0000BEEF at 0x3 -> write word0 BE=1000 DI=0xEF000000, then word1 BE=0001 DI=0x000000BE; RSP_VALID at E2. Readback LW 0x0 = 0xEF332211; LW 0x4 = 0x887766BE.
- AWIDTH=12, LW at byte 0x3FFE -> MEM_ADDR 0xFFF then 0x000, BE ignored (reads). Result = {word0[15:0], word0xFFF[31:16]}.
- REQ_SIZE=3 -> MEM_CSN stays 1; RSP_VALID with RSP_ERR=1 at E1. Separately, SW 0x12345678 at 0x0 with RSTn asserted during ACC0 before the edge -> MEM_CSN=1 at once; word0 unchanged; REQ_READY=1 after release.
